// File: rtl/addr_decoder_n_if.sv
// Bus bundle for addr_decoder_n: master selection, addressing, serial data and slave handshakes.
// The master modport drives the bus (masters and slaves); the slave modport is the decoder side.
interface addr_decoder_n_if #(
  parameter int NUM_SLAVES  = 3,
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 14
);
  localparam int MS_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] m_tx;
  logic [MS_W-1:0]        m_sel;
  logic [ADDR_W-1:0]      addr;
  logic                   addr_rdy;
  logic [NUM_SLAVES-1:0]  s_tx;
  logic [NUM_SLAVES-1:0]  s_split;
  logic [NUM_SLAVES-1:0]  s_rx;
  logic                   slv_ready;
  logic                   err;
  logic [NUM_SLAVES-1:0]  split_pending;

  modport master (
    output m_tx, m_sel, addr, addr_rdy, s_tx, s_split,
    input  s_rx, slv_ready, err, split_pending
  );

  modport slave (
    input  m_tx, m_sel, addr, addr_rdy, s_tx, s_split,
    output s_rx, slv_ready, err, split_pending
  );
endinterface

// File: rtl/addr_decoder_n.sv
// Address decoder / serial forwarder: selects a slave from the top address bits, waits for its
// acknowledge (or split), then forwards DATA_BITS serial bits from the latched master.
module addr_decoder_n #(
  parameter int                    NUM_SLAVES  = 3,
  parameter int                    NUM_MASTERS = 2,
  parameter int                    ADDR_W      = 14,
  parameter int                    DATA_BITS   = 8,
  parameter int                    TIMEOUT     = 16,
  parameter logic [NUM_SLAVES-1:0] SPLIT_EN    = 'b001
) (
  input logic             clk,
  input logic             rst,
  addr_decoder_n_if.slave bus
);
  localparam int SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int MS_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_MAX = (TIMEOUT > DATA_BITS) ? TIMEOUT : DATA_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [NUM_SLAVES-1:0]  ONE_S  = NUM_SLAVES'(1);
  localparam logic [NUM_MASTERS-1:0] ONE_M  = NUM_MASTERS'(1);
  localparam logic [SEL_W:0]         NS_LIM = (SEL_W+1)'(NUM_SLAVES);
  localparam logic [MS_W:0]          NM_LIM = (MS_W+1)'(NUM_MASTERS);
  localparam logic [CNT_W-1:0]       T_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]       B_LAST = CNT_W'(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_SPLIT, S_GRANTED, S_DATA, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [MS_W-1:0]       msel_q, msel_d;
  logic                  msel_ok_q, msel_ok_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] s_rx_q, s_rx_d;
  logic                  rdy_q, rdy_d;
  logic                  err_q, err_d;
  logic [NUM_SLAVES-1:0] pend_q, pend_d;

  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  sel_ok, ack, split_req, m_bit;
  logic                  found;
  logic [SEL_W-1:0]      res_idx;

  // Only the top SEL_W address bits select a slave; the rest are don't-care.
  logic unused_addr;
  assign unused_addr = ^bus.addr[ADDR_W-SEL_W-1:0];

  // One-hot masks avoid out-of-range indexing when sel or m_sel exceeds the populated count.
  assign sel_oh    = ONE_S << sel_q;
  assign sel_ok    = {1'b0, sel_q} < NS_LIM;
  assign ack       = |(~bus.s_tx & sel_oh);
  assign split_req = |(bus.s_split & SPLIT_EN & sel_oh);
  assign m_bit     = msel_ok_q ? |(bus.m_tx & (ONE_M << msel_q)) : 1'b1;

  always_comb begin
    found   = 1'b0;
    res_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!found && pend_q[i] && !bus.s_tx[i]) begin
        found   = 1'b1;
        res_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    msel_d    = msel_q;
    msel_ok_d = msel_ok_q;
    cnt_d     = cnt_q;
    s_rx_d    = s_rx_q;
    rdy_d     = rdy_q;
    pend_d    = pend_q;
    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b0;
        cnt_d = '0;
        if (bus.addr_rdy) begin
          sel_d   = bus.addr[ADDR_W-1 -: SEL_W];
          state_d = S_REQ;
        end else if (found) begin
          sel_d   = res_idx;
          rdy_d   = 1'b1;
          state_d = S_GRANTED;
        end
      end
      S_REQ: begin
        if (!sel_ok) begin
          state_d = S_ERR;
        end else begin
          s_rx_d  = s_rx_q & ~sel_oh;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack) begin
          s_rx_d  = '1;
          rdy_d   = 1'b1;
          state_d = S_GRANTED;
        end else if (split_req) begin
          state_d = S_SPLIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == T_LAST) state_d = S_ERR;
        end
      end
      S_SPLIT: begin
        pend_d  = pend_q | sel_oh;
        s_rx_d  = s_rx_q | sel_oh;
        rdy_d   = 1'b0;
        state_d = S_IDLE;
      end
      S_GRANTED: begin
        msel_d    = bus.m_sel;
        msel_ok_d = {1'b0, bus.m_sel} < NM_LIM;
        pend_d    = pend_q & ~sel_oh;
        cnt_d     = '0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == B_LAST) begin
          s_rx_d  = '1;
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          s_rx_d = m_bit ? '1 : ~sel_oh;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        s_rx_d  = '1;
        rdy_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      msel_q    <= '0;
      msel_ok_q <= 1'b0;
      cnt_q     <= '0;
      s_rx_q    <= '1;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      msel_q    <= msel_d;
      msel_ok_q <= msel_ok_d;
      cnt_q     <= cnt_d;
      s_rx_q    <= s_rx_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  assign bus.s_rx          = s_rx_q;
  assign bus.slv_ready     = rdy_q;
  assign bus.err           = err_q;
  assign bus.split_pending = pend_q;
endmodule

// File: tb/tb_addr_decoder_n.sv
// Directed bench for addr_decoder_n: per-cycle vector table plus hand-written split,
// timeout and mid-transfer reset sequences.
module tb_addr_decoder_n;
  localparam int NS = 3;
  localparam int NM = 2;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addr_decoder_n_if #(.NUM_SLAVES(NS), .NUM_MASTERS(NM), .ADDR_W(AW)) bus ();

  addr_decoder_n #(
    .NUM_SLAVES(NS), .NUM_MASTERS(NM), .ADDR_W(AW),
    .DATA_BITS(8), .TIMEOUT(16), .SPLIT_EN(3'b001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic          ardy;
    logic [AW-1:0] addr;
    logic [NS-1:0] stx;
    logic [NS-1:0] ssplit;
    logic          msel;
    logic [NM-1:0] mtx;
    logic [NS-1:0] e_srx;
    logic          e_rdy;
    logic          e_err;
    logic [NS-1:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ardy, input logic [AW-1:0] a,
                     input logic [NS-1:0] stx, input logic [NS-1:0] ssplit,
                     input logic msel, input logic [NM-1:0] mtx,
                     input logic [NS-1:0] e_srx, input logic e_rdy, input logic e_err,
                     input logic [NS-1:0] e_pend);
    vec_t v;
    v.rst = r; v.ardy = ardy; v.addr = a; v.stx = stx; v.ssplit = ssplit;
    v.msel = msel; v.mtx = mtx; v.e_srx = e_srx; v.e_rdy = e_rdy;
    v.e_err = e_err; v.e_pend = e_pend;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, then return just after the next rising edge.
  task automatic cyc(input logic r, input logic ardy, input logic [AW-1:0] a,
                     input logic [NS-1:0] stx, input logic [NS-1:0] ssplit,
                     input logic msel, input logic [NM-1:0] mtx);
    @(negedge clk);
    rst          = r;
    bus.addr_rdy = ardy;
    bus.addr     = a;
    bus.s_tx     = stx;
    bus.s_split  = ssplit;
    bus.m_sel    = msel;
    bus.m_tx     = mtx;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [NS-1:0] srx, input logic rdy,
                     input logic er, input logic [NS-1:0] pend);
    checks++;
    if ({bus.s_rx, bus.slv_ready, bus.err, bus.split_pending} !== {srx, rdy, er, pend}) begin
      errors++;
      $display("FAIL %s: got s_rx=%b rdy=%b err=%b pend=%b, want s_rx=%b rdy=%b err=%b pend=%b",
               nm, bus.s_rx, bus.slv_ready, bus.err, bus.split_pending, srx, rdy, er, pend);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] d1, d2, d3;
    logic       b;
    d1 = 8'b10110010;
    d2 = 8'b01101001;
    d3 = 8'b11110000;

    rst = 1'b1;
    bus.addr_rdy = 1'b0; bus.addr = '0; bus.s_tx = '1; bus.s_split = '0;
    bus.m_sel = 1'b0; bus.m_tx = '1;

    // Transfer to slave 1, addr_rdy accepted on first edge after reset release.
    add(1, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11, 3'b111, 0, 0, 3'b000);
    add(0, 1, 14'h1000, 3'b111, 3'b000, 0, 2'b11, 3'b111, 0, 0, 3'b000);
    add(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11, 3'b101, 0, 0, 3'b000);
    add(0, 1, 14'h3000, 3'b111, 3'b000, 0, 2'b11, 3'b101, 0, 0, 3'b000);
    add(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11, 3'b101, 0, 0, 3'b000);
    add(0, 0, 14'h0000, 3'b101, 3'b000, 0, 2'b11, 3'b111, 1, 0, 3'b000);
    add(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11, 3'b111, 1, 0, 3'b000);
    for (int k = 0; k < 8; k++) begin
      b = d1[7-k];
      add(0, 0, 14'h0000, 3'b111, 3'b000, k[0], {~b, b}, b ? 3'b111 : 3'b101, 1, 0, 3'b000);
    end
    add(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11, 3'b111, 0, 0, 3'b000);
    add(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11, 3'b111, 0, 0, 3'b000);
    // Out-of-range slave index.
    add(0, 1, 14'h3000, 3'b111, 3'b000, 0, 2'b11, 3'b111, 0, 0, 3'b000);
    add(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11, 3'b111, 0, 1, 3'b000);
    add(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11, 3'b111, 0, 0, 3'b000);
    add(0, 0, 14'h0000, 3'b000, 3'b000, 0, 2'b11, 3'b111, 0, 0, 3'b000);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].ardy, vecs[i].addr, vecs[i].stx, vecs[i].ssplit,
          vecs[i].msel, vecs[i].mtx);
      chk($sformatf("vec%0d", i), vecs[i].e_srx, vecs[i].e_rdy, vecs[i].e_err, vecs[i].e_pend);
    end

    // Split on slave 0, then resume via its acknowledge; data from master 1.
    cyc(0, 1, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("a_req",      3'b111, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("a_wait",     3'b110, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b001, 0, 2'b11); chk("a_split",    3'b110, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("a_pending",  3'b111, 0, 0, 3'b001);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("a_hold",     3'b111, 0, 0, 3'b001);
    cyc(0, 0, 14'h0000, 3'b110, 3'b000, 0, 2'b11); chk("a_resume",   3'b111, 1, 0, 3'b001);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 1, 2'b11); chk("a_granted",  3'b111, 1, 0, 3'b000);
    for (int k = 0; k < 8; k++) begin
      b = d2[7-k];
      cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, {b, ~b});
      chk($sformatf("a_bit%0d", k), b ? 3'b111 : 3'b110, 1, 0, 3'b000);
    end
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("a_end",      3'b111, 0, 0, 3'b000);

    // Timeout on slave 2; its split request is not permitted and must be ignored.
    cyc(0, 1, 14'h2000, 3'b111, 3'b000, 0, 2'b11); chk("b_req",      3'b111, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b100, 0, 2'b11); chk("b_wait",     3'b011, 0, 0, 3'b000);
    for (int k = 0; k < 15; k++) begin
      cyc(0, 0, 14'h0000, 3'b111, 3'b100, 0, 2'b11);
      chk($sformatf("b_wait%0d", k), 3'b011, 0, 0, 3'b000);
    end
    cyc(0, 0, 14'h0000, 3'b111, 3'b100, 0, 2'b11); chk("b_err",      3'b011, 0, 1, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("b_idle",     3'b111, 0, 0, 3'b000);

    // New address to a split-pending slave; ack beats split; reset at data bit 4.
    cyc(0, 1, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("c_req0",     3'b111, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("c_wait0",    3'b110, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b001, 0, 2'b11); chk("c_split",    3'b110, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("c_pending",  3'b111, 0, 0, 3'b001);
    cyc(0, 1, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("c_req1",     3'b111, 0, 0, 3'b001);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("c_wait1",    3'b110, 0, 0, 3'b001);
    cyc(0, 0, 14'h0000, 3'b110, 3'b001, 0, 2'b11); chk("c_ack_wins", 3'b111, 1, 0, 3'b001);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("c_pend_clr", 3'b111, 1, 0, 3'b000);
    for (int k = 0; k < 5; k++) begin
      b = d3[7-k];
      cyc(0, 0, 14'h0000, 3'b111, 3'b000, 1, {~b, b});
      chk($sformatf("c_bit%0d", k), b ? 3'b111 : 3'b110, 1, 0, 3'b000);
    end
    #2 rst = 1'b1;
    #1 chk("c_rst_async", 3'b111, 0, 0, 3'b000);

    // Reset clears an outstanding split flag immediately.
    cyc(0, 1, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("d_req",      3'b111, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("d_wait",     3'b110, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b001, 0, 2'b11); chk("d_split",    3'b110, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b111, 3'b000, 0, 2'b11); chk("d_pending",  3'b111, 0, 0, 3'b001);
    #2 rst = 1'b1;
    #1 chk("d_rst_pend", 3'b111, 0, 0, 3'b000);
    cyc(0, 0, 14'h0000, 3'b110, 3'b000, 0, 2'b11); chk("d_after",    3'b111, 0, 0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_decoder_n.md
ADDR_DECODER_N -- requirements
Module: addr_decoder_n

Interface
REQ-001 SHALL have parameter NUM_SLAVES, 3, number of serial slaves (2..8).
REQ-002 SHALL have parameter NUM_MASTERS, 2, number of serial masters (1..4).
REQ-003 SHALL have parameter ADDR_W, 14, address width; slave index = addr[ADDR_W-1 -: SEL_W], SEL_W = max(1, clog2(NUM_SLAVES)).
REQ-004 SHALL have parameter DATA_BITS, 8, serial bits forwarded per transfer (1..255).
REQ-005 SHALL have parameter TIMEOUT, 16, WAIT cycles before error (>=2).
REQ-006 SHALL have parameter SPLIT_EN, 'b001 (NUM_SLAVES bits), per-slave split permission.
REQ-007 SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-009 SHALL have port m_tx  in  NUM_MASTERS  serial data from each master.
REQ-010 SHALL have port m_sel  in  MS_W = max(1, clog2(NUM_MASTERS))  index of master owning the bus.
REQ-011 SHALL have port addr  in  ADDR_W  target address.
REQ-012 SHALL have port addr_rdy  in  1  address-valid strobe.
REQ-013 SHALL have port s_tx  in  NUM_SLAVES  active-low slave acknowledge, one per slave.
REQ-014 SHALL have port s_split  in  NUM_SLAVES  active-high slave split request.
REQ-015 SHALL have port s_rx  out  NUM_SLAVES  serial line to each slave, idle high.
REQ-016 SHALL have port slv_ready  out  1  high while slave is granted and data is flowing.
REQ-017 SHALL have port err  out  1  one-cycle pulse on bad address or timeout.
REQ-018 SHALL have port split_pending  out  NUM_SLAVES  per-slave outstanding split flag.

Function
REQ-019 SHALL register all outputs; states IDLE, REQ, WAIT, SPLIT, GRANTED, DATA, ERR.
REQ-020 IDLE: slv_ready=0, counters=0; addr_rdy=1 -> latch slave index sel, go REQ; else lowest i with split_pending[i]=1 and s_tx[i]=0 -> sel=i, slv_ready<=1, go GRANTED; addr_rdy has priority over resume.
REQ-021 REQ: sel>=NUM_SLAVES -> ERR; else s_rx[sel]<=0, timer<=0, go WAIT.
REQ-022 WAIT: s_tx[sel]=0 -> all s_rx<=1, slv_ready<=1, go GRANTED; else s_split[sel]=1 and SPLIT_EN[sel]=1 -> go SPLIT; else timer increments, timer==TIMEOUT-1 -> go ERR; ack beats split when simultaneous; s_split ignored where SPLIT_EN=0.
REQ-023 SPLIT (1 cycle): split_pending[sel]<=1, s_rx[sel]<=1, slv_ready=0, go IDLE.
REQ-024 GRANTED (1 cycle): latch m_sel; clear split_pending[sel]; go DATA.
REQ-025 DATA: exactly DATA_BITS cycles, s_rx[sel]<=m_tx[latched m_sel] each cycle, other s_rx held 1; after last bit s_rx[sel]<=1, slv_ready<=0, go IDLE.
REQ-026 m_sel >= NUM_MASTERS at GRANTED SHALL forward constant 1 (idle line).
REQ-027 ERR (1 cycle): err=1, all s_rx<=1, slv_ready=0, go IDLE; err=0 in all other states.
REQ-028 addr_rdy outside IDLE SHALL be ignored (not queued).
REQ-029 A new address targeting a slave with split pending SHALL proceed normally; the flag clears on its GRANTED.
REQ-030 Latency addr_rdy -> s_rx[sel] low SHALL be 2 cycles; ack -> slv_ready high 1 cycle; ack -> first data bit 3 cycles.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, s_rx=all 1, slv_ready=0, err=0, split_pending=0, counters=0, including mid-transfer.
REQ-032 After rst deasserts, first addr_rdy SHALL be accepted on the first rising edge.

Verification
REQ-033 addr=14'h1000, addr_rdy 1 cycle, s_tx[1] low 3 cycles later, m_sel=0, m_tx[0]=10110010 -> s_rx[1] low then 8 bits 10110010, slv_ready high 10 cycles, then idle.
REQ-034 addr=14'h0000, s_split[0]=1 in WAIT -> split_pending=001, s_rx all 1; later s_tx[0]=0 -> resume via GRANTED, pending cleared, 8 bits forwarded from m_tx[m_sel].
REQ-035 addr=14'h3000 (index 3, NUM_SLAVES=3) -> err pulse 1 cycle, no s_rx low, back to IDLE.
REQ-036 addr=14'h2000, no ack for 16 cycles -> err pulse, s_rx[2] back to 1; s_split[2]=1 during WAIT ignored.
REQ-037 Simultaneous s_tx[0]=0 and s_split[0]=1 in WAIT -> grant, no split; rst asserted at bit 4 of DATA -> all outputs at reset values same cycle.
